counter_down_chain: RTL and testbench

Parametrised cascaded down-counter: DIGITS chained digit counters, each W bits wide, each with its own modulus. Generalises the single mod-6 timer digit into a complete multi-digit countdown, e.g. mm:ss with the default moduli. Adds per-digit borrow chaining, load clamping, a shadow reload register, one-shot/auto-reload modes and a registered done pulse. Sits in the timer datapath between the control FSM (load/en/mode) and the display decoders.

---
 rtl/counter_down_chain.sv | 94 +++++++++
 tb/tb_counter_down_chain.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/counter_down_chain.sv
// Cascaded multi-digit down-counter with per-digit moduli, load clamping,
// a shadow reload register, one-shot/auto-reload modes and a done pulse.
module counter_down_chain #(
  parameter int unsigned             DIGITS = 4,
  parameter int unsigned             W      = 4,
  parameter logic [DIGITS*W-1:0]     MAXV   = {4'd5, 4'd9, 4'd5, 4'd9}
) (
  input  logic                clk,
  input  logic                clearn,
  input  logic [DIGITS*W-1:0] in,
  input  logic                load,
  input  logic                en,
  input  logic                mode,
  output logic [DIGITS*W-1:0] count,
  output logic [DIGITS-1:0]   tc,
  output logic                count_end,
  output logic                done
);

  logic [DIGITS*W-1:0] count_q, count_d;
  logic [DIGITS*W-1:0] shadow_q, shadow_d;
  logic                done_q, done_d;

  logic [DIGITS*W-1:0] clamped;
  logic [DIGITS*W-1:0] decremented;
  logic [DIGITS-1:0]   tc_w;
  logic                all_zero;

  // Per-digit borrow chain, clamp of the load value and terminal counts.
  always_comb begin
    logic         lower_zero;
    logic [W-1:0] dig;
    logic [W-1:0] mx;
    logic [W-1:0] ld;
    clamped     = '0;
    decremented = '0;
    tc_w        = '0;
    lower_zero  = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = count_q[i*W +: W];
      mx  = MAXV[i*W +: W];
      ld  = in[i*W +: W];
      clamped[i*W +: W] = (ld > mx) ? mx : ld;
      if (lower_zero) begin
        decremented[i*W +: W] = (dig == '0) ? mx : dig - 1'b1;
      end else begin
        decremented[i*W +: W] = dig;
      end
      lower_zero = lower_zero & (dig == '0);
      tc_w[i]    = en & lower_zero;
    end
    all_zero = lower_zero;
  end

  // Next-state selection: load beats enable beats hold.
  always_comb begin
    count_d  = count_q;
    shadow_d = shadow_q;
    done_d   = 1'b0;
    if (load) begin
      count_d  = clamped;
      shadow_d = clamped;
    end else if (en) begin
      if (all_zero) begin
        // Expiry: reload only in auto-reload mode; never wrap to all-max.
        if (mode) begin
          count_d = shadow_q;
        end
      end else begin
        count_d = decremented;
        done_d  = (decremented == '0);
      end
    end
  end

  // State registers with asynchronous active-low clear.
  always_ff @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      count_q  <= '0;
      shadow_q <= '0;
      done_q   <= 1'b0;
    end else begin
      count_q  <= count_d;
      shadow_q <= shadow_d;
      done_q   <= done_d;
    end
  end

  assign count     = count_q;
  assign tc        = tc_w;
  assign count_end = all_zero;
  assign done      = done_q;

endmodule

// File: tb/tb_counter_down_chain.sv
// Self-checking bench: mixed-radix integer model of the countdown plus
// directed literal checks and a randomized phase.
module tb_counter_down_chain;

  localparam int unsigned DIGITS = 4;
  localparam int unsigned W      = 4;
  localparam logic [15:0] MAXV   = {4'd5, 4'd9, 4'd5, 4'd9};

  logic        clk = 1'b0;
  logic        clearn = 1'b0;
  logic [15:0] din = '0;
  logic        load = 1'b0;
  logic        en = 1'b0;
  logic        mode = 1'b0;
  logic [15:0] count;
  logic [3:0]  tc;
  logic        count_end;
  logic        done;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;

  counter_down_chain #(.DIGITS(DIGITS), .W(W), .MAXV(MAXV)) dut (
    .clk(clk), .clearn(clearn), .in(din), .load(load), .en(en), .mode(mode),
    .count(count), .tc(tc), .count_end(count_end), .done(done)
  );

  always #5 clk = ~clk;

  // Mixed-radix helpers: radix of digit i is MAXV field + 1.
  function automatic int radix(input int i);
    logic [15:0] m;
    m = MAXV;
    return int'(m[i*4 +: 4]) + 1;
  endfunction

  function automatic int weight(input int i);
    int w;
    w = 1;
    for (int j = 0; j < i; j++) w = w * radix(j);
    return w;
  endfunction

  function automatic int clamp_to_val(input logic [15:0] v);
    int s, d;
    s = 0;
    for (int i = 0; i < 4; i++) begin
      d = int'(v[i*4 +: 4]);
      if (d > radix(i) - 1) d = radix(i) - 1;
      s = s + d * weight(i);
    end
    return s;
  endfunction

  function automatic logic [15:0] to_digits(input int v);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 4; i++) r[i*4 +: 4] = 4'((v / weight(i)) % radix(i));
    return r;
  endfunction

  // Reference model: the count is a plain integer of remaining time.
  int mv = 0;
  int ms = 0;
  bit md = 1'b0;

  always @(posedge clk or negedge clearn) begin
    if (!clearn) begin
      mv <= 0; ms <= 0; md <= 1'b0;
    end else if (load) begin
      mv <= clamp_to_val(din); ms <= clamp_to_val(din); md <= 1'b0;
    end else if (en) begin
      if (mv == 0) begin
        if (mode) mv <= ms;
        md <= 1'b0;
      end else begin
        mv <= mv - 1;
        md <= (mv == 1);
      end
    end else begin
      md <= 1'b0;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    if (chk_en) begin
      logic [3:0] etc;
      for (int i = 0; i < 4; i++) etc[i] = en && (mv % weight(i + 1) == 0);
      check("model_count", 32'(count), 32'(to_digits(mv)));
      check("model_tc", 32'(tc), 32'(etc));
      check("model_count_end", 32'(count_end), 32'(mv == 0));
      check("model_done", 32'(done), 32'(md));
    end
  end

  task automatic tick;
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input bit l, input bit e, input bit m, input logic [15:0] v);
    load = l; en = e; mode = m; din = v;
  endtask

  initial begin
    tick;
    tick;
    clearn = 1'b1;
    chk_en = 1'b1;
    check("reset_count", 32'(count), 32'h0);
    check("reset_done", 32'(done), 32'h0);
    check("reset_end", 32'(count_end), 32'h1);

    // Reset in the middle of a count.
    drive(1, 0, 0, 16'h1234); tick;
    drive(0, 1, 0, 16'h0000); tick; tick; tick;
    check("pre_reset_count", 32'(count), 32'h1231);
    clearn = 1'b0;
    #1;
    check("async_reset_count", 32'(count), 32'h0);
    check("async_reset_done", 32'(done), 32'h0);
    #1 clearn = 1'b1;
    drive(0, 0, 0, 16'h0000); tick;

    // Borrow ripples through three zero digits.
    drive(1, 0, 0, 16'h1000); tick;
    drive(0, 1, 0, 16'h0000);
    #1 check("borrow_tc", 32'(tc), 32'h7);
    tick;
    check("borrow_count", 32'(count), 32'h0959);
    check("borrow_done", 32'(done), 32'h0);

    // One-shot expiry.
    drive(1, 0, 0, 16'h0002); tick;
    drive(0, 1, 0, 16'h0000); tick;
    check("oneshot_1", 32'(count), 32'h0001);
    tick;
    check("oneshot_0", 32'(count), 32'h0000);
    check("oneshot_done", 32'(done), 32'h1);
    tick;
    check("oneshot_hold", 32'(count), 32'h0000);
    check("oneshot_done_low", 32'(done), 32'h0);
    check("oneshot_tc3", 32'(tc[3]), 32'h1);

    // Auto-reload with a three-cycle done period.
    drive(1, 0, 1, 16'h0002); tick;
    drive(0, 1, 1, 16'h0000); tick;
    check("reload_a1", 32'(count), 32'h0001);
    tick;
    check("reload_a0", 32'(count), 32'h0000);
    check("reload_done_a", 32'(done), 32'h1);
    tick;
    check("reload_back", 32'(count), 32'h0002);
    check("reload_done_low", 32'(done), 32'h0);
    tick;
    check("reload_b1", 32'(count), 32'h0001);
    tick;
    check("reload_b0", 32'(count), 32'h0000);
    check("reload_done_b", 32'(done), 32'h1);

    // Clamp, and load beats enable.
    drive(1, 1, 0, 16'hFFFF); tick;
    check("clamp_load", 32'(count), 32'h5959);
    drive(0, 1, 0, 16'h0000); tick;
    check("clamp_dec", 32'(count), 32'h5958);

    // Hold, then toggle mode while counting.
    drive(1, 0, 0, 16'h0130); tick;
    drive(0, 0, 0, 16'h0000);
    for (int i = 0; i < 5; i++) tick;
    check("hold_count", 32'(count), 32'h0130);
    check("hold_done", 32'(done), 32'h0);
    for (int i = 0; i < 3; i++) begin
      drive(0, 1, (i % 2 == 0), 16'h0000); tick;
    end
    check("mode_toggle_count", 32'(count), 32'h0127);

    // Randomized phase, model checked every cycle.
    for (int c = 0; c < 4000; c++) begin
      logic [15:0] v;
      v = 16'($urandom);
      if ($urandom_range(0, 1) == 1) v = v & 16'h0013;
      drive($urandom_range(0, 24) == 0, $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)), v);
      tick;
      if ($urandom_range(0, 299) == 0) begin
        #1 clearn = 1'b0;
        #1 clearn = 1'b1;
      end
    end

    chk_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
